prog_clk_divider: RTL and testbench

PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

---
 rtl/prog_clk_divider.sv | 93 +++++++++
 tb/tb_prog_clk_divider.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider with 50% duty registered outputs.
// Divide values are double-buffered and only applied at a half-period boundary.
module prog_clk_divider #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 16,
  parameter int RESET_DIV = 49
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending
);

  localparam logic [CNT_W-1:0] RESET_A = CNT_W'(RESET_DIV);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] a_q, a_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] c_q, c_d;
    logic             f_q, f_d;
    logic             o_q, o_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] slice;

    assign slice = div_val[i*CNT_W +: CNT_W];

    always_comb begin
      a_d    = a_q;
      p_d    = p_q;
      f_d    = f_q;
      c_d    = c_q;
      o_d    = o_q;
      tick_d = 1'b0;
      if (!en[i]) begin
        c_d = '0;
        o_d = 1'b0;
        // Disabled channel has no period in flight, so a load goes straight to A.
        if (load[i]) begin
          a_d = slice;
          f_d = 1'b0;
        end
      end else begin
        if (sync) begin
          c_d = '0;
          o_d = 1'b0;
        end else if (c_q == a_q) begin
          c_d    = '0;
          o_d    = ~o_q;
          tick_d = ~o_q;
          if (f_q) begin
            a_d = p_q;
            f_d = 1'b0;
          end
        end else begin
          c_d = c_q + 1'b1;
        end
        // A same-cycle load overrides the flag clear from the transfer above.
        if (load[i]) begin
          p_d = slice;
          f_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q    <= RESET_A;
        p_q    <= '0;
        f_q    <= 1'b0;
        c_q    <= '0;
        o_q    <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        a_q    <= a_d;
        p_q    <= p_d;
        f_q    <= f_d;
        c_q    <= c_d;
        o_q    <= o_d;
        tick_q <= tick_d;
      end
    end

    assign clk_out[i] = o_q;
    assign tick[i]    = tick_q;
    assign pending[i] = f_q;
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed self-checking bench for prog_clk_divider (two channels, 16-bit counters).
module tb_prog_clk_divider;

  logic        clk;
  logic        rst_n;
  logic [1:0]  en;
  logic        sync;
  logic [1:0]  load;
  logic [31:0] div_val;
  logic [1:0]  clk_out;
  logic [1:0]  tick;
  logic [1:0]  pending;

  int n_cmp = 0;
  int n_err = 0;

  prog_clk_divider #(.NUM_CH(2), .CNT_W(16), .RESET_DIV(49)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sync    (sync),
    .load    (load),
    .div_val (div_val),
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 2'b00;
    sync    = 1'b0;
    load    = 2'b00;
    div_val = '0;
    cyc(2);
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_tick",    32'(tick),    32'h0);
    chk("rst_pending", 32'(pending), 32'h0);

    // Defaults: divide by 100, first rise on the 50th enabled edge
    rst_n = 1'b1;
    en    = 2'b11;
    cyc(49);
    chk("def_low_e49",  32'(clk_out), 32'h0);
    cyc(1);
    chk("def_rise_e50", 32'(clk_out), 32'h3);
    chk("def_tick_e50", 32'(tick),    32'h3);
    cyc(1);
    chk("def_tick_e51", 32'(tick),    32'h0);
    cyc(48);
    chk("def_high_e99", 32'(clk_out), 32'h3);
    cyc(1);
    chk("def_fall_e100", 32'(clk_out), 32'h0);
    chk("def_notick_e100", 32'(tick),  32'h0);
    cyc(49);
    chk("def_low_e149", 32'(clk_out), 32'h0);
    cyc(1);
    chk("def_rise_e150", 32'(clk_out), 32'h3);
    chk("def_tick_e150", 32'(tick),    32'h3);

    // A=3, load 0 mid-half-period
    en      = 2'b00;
    load    = 2'b01;
    div_val = {16'd0, 16'd3};
    cyc(1);
    chk("dis_load_pend", 32'(pending[0]), 32'h0);
    chk("dis_clk_out",   32'(clk_out),    32'h0);
    load = 2'b00;
    en   = 2'b01;
    cyc(1);
    load    = 2'b01;
    div_val = {16'd0, 16'd0};
    cyc(1);
    load = 2'b00;
    chk("a3_pend_set", 32'(pending[0]), 32'h1);
    chk("a3_low_e2",   32'(clk_out[0]), 32'h0);
    cyc(1);
    chk("a3_low_e3",   32'(clk_out[0]), 32'h0);
    cyc(1);
    chk("a3_rise_e4",  32'(clk_out[0]), 32'h1);
    chk("a3_pend_clr", 32'(pending[0]), 32'h0);
    chk("a3_tick_e4",  32'(tick[0]),    32'h1);
    cyc(1);
    chk("a0_fall_e5",  32'(clk_out[0]), 32'h0);
    cyc(1);
    chk("a0_rise_e6",  32'(clk_out[0]), 32'h1);
    chk("a0_tick_e6",  32'(tick[0]),    32'h1);
    cyc(1);
    chk("a0_fall_e7",  32'(clk_out[0]), 32'h0);

    // Load at terminal: P=7 held, new value 2
    en      = 2'b00;
    load    = 2'b01;
    div_val = {16'd0, 16'd1};
    cyc(1);
    en      = 2'b01;
    div_val = {16'd0, 16'd7};
    cyc(1);
    chk("lt_pend_p7", 32'(pending[0]), 32'h1);
    div_val = {16'd0, 16'd2};
    cyc(1);
    load = 2'b00;
    chk("lt_rise",      32'(clk_out[0]), 32'h1);
    chk("lt_pend_kept", 32'(pending[0]), 32'h1);
    cyc(7);
    chk("lt_high_7",    32'(clk_out[0]), 32'h1);
    chk("lt_pend_7",    32'(pending[0]), 32'h1);
    cyc(1);
    chk("lt_fall_8",    32'(clk_out[0]), 32'h0);
    chk("lt_pend_clr",  32'(pending[0]), 32'h0);
    cyc(2);
    chk("lt_low_2",     32'(clk_out[0]), 32'h0);
    cyc(1);
    chk("lt_rise_3",    32'(clk_out[0]), 32'h1);

    // Two channels A=4 / A=9, sync at an arbitrary point
    en      = 2'b00;
    load    = 2'b11;
    div_val = {16'd9, 16'd4};
    cyc(1);
    load = 2'b00;
    en   = 2'b11;
    cyc(13);
    sync = 1'b1;
    cyc(1);
    sync = 1'b0;
    chk("sync_low", 32'(clk_out), 32'h0);
    for (int k = 1; k <= 40; k++) begin
      logic [1:0] exp_o;
      logic [1:0] exp_t;
      cyc(1);
      exp_o[0] = ((k / 5) % 2) == 1;
      exp_o[1] = ((k / 10) % 2) == 1;
      exp_t[0] = (k % 10) == 5;
      exp_t[1] = (k % 20) == 10;
      chk($sformatf("sync_out_k%0d", k),  32'(clk_out), 32'(exp_o));
      chk($sformatf("sync_tick_k%0d", k), 32'(tick),    32'(exp_t));
    end

    // Drop en mid-high, load 1 while disabled, re-enable
    cyc(5);
    chk("dis_mid_high", 32'(clk_out[0]), 32'h1);
    en = 2'b10;
    cyc(1);
    chk("dis_forced_low", 32'(clk_out[0]), 32'h0);
    chk("dis_tick_low",   32'(tick[0]),    32'h0);
    load    = 2'b01;
    div_val = {16'd0, 16'd1};
    cyc(1);
    load = 2'b00;
    chk("dis_pend_zero", 32'(pending[0]), 32'h0);
    en = 2'b11;
    cyc(1);
    chk("re_e1", 32'(clk_out[0]), 32'h0);
    cyc(1);
    chk("re_e2", 32'(clk_out[0]), 32'h1);
    cyc(1);
    chk("re_e3", 32'(clk_out[0]), 32'h1);
    cyc(1);
    chk("re_e4", 32'(clk_out[0]), 32'h0);
    cyc(1);
    chk("re_e5", 32'(clk_out[0]), 32'h0);
    cyc(1);
    chk("re_e6", 32'(clk_out[0]), 32'h1);

    // Short async reset pulse mid-period
    load    = 2'b10;
    div_val = {16'd5, 16'd0};
    cyc(1);
    load = 2'b00;
    chk("pre_rst_pend", 32'(pending), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_clk_out", 32'(clk_out), 32'h0);
    chk("arst_tick",    32'(tick),    32'h0);
    chk("arst_pending", 32'(pending), 32'h0);
    #1 rst_n = 1'b1;
    cyc(49);
    chk("post_rst_e49", 32'(clk_out), 32'h0);
    cyc(1);
    chk("post_rst_e50", 32'(clk_out), 32'h3);
    chk("post_rst_tick", 32'(tick),   32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
